// File: rtl/score_pio_pkg.sv
// Shared constants for the score counter PIO.
// Register addresses, CTRL bit positions and channel limit.
package score_pio_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;
    localparam logic [2:0] ADDR_THRESH = 3'd6;

    localparam int CTRL_INC_EN    = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_FREEZE    = 2;
    localparam int CTRL_CLEAR_ALL = 3;

    localparam int MAX_CH = 4;

endpackage

// File: rtl/score_pio_channel.sv
// One saturating score counter with load, clear and win detection.
// win_edge fires only when an increment crosses the threshold.
module score_channel #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc_ok,
    input  logic [WIDTH-1:0] thresh,
    output logic [WIDTH-1:0] score,
    output logic             win_edge,
    output logic             win
);

    logic             at_max;
    logic             bump;
    logic             thr_on;
    logic [WIDTH-1:0] nxt;

    assign at_max   = &score;
    assign bump     = inc_ok && !clear && !load && !at_max;
    assign thr_on   = |thresh;
    assign nxt      = score + WIDTH'(1);
    assign win_edge = bump && thr_on && (score < thresh) && (nxt >= thresh);
    assign win      = thr_on && (score >= thresh);

    // counter: clear beats CPU load beats increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            score <= '0;
        else if (clear)
            score <= '0;
        else if (load)
            score <= load_val;
        else if (bump)
            score <= nxt;
    end

endmodule

// File: rtl/avalon_score_counter_pio.sv
// Avalon-MM scoreboard PIO: score counters, threshold, win status, irq.
// Top handles decode, CTRL/STATUS/THRESH and the read mux.
module avalon_score_counter_pio
    import score_pio_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int WIDTH     = 7,
    parameter int MAX_SCORE = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    input  logic [NUM_CH-1:0]       inc,
    output logic [NUM_CH*WIDTH-1:0] out_port,
    output logic [NUM_CH-1:0]       win,
    output logic                    irq
);

    logic [2:0]        ctrl_q;
    logic [NUM_CH-1:0] status_q;
    logic [WIDTH-1:0]  thresh_q;

    logic              wr;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_thresh;
    logic              clear_all;
    logic              frozen;
    logic [NUM_CH-1:0] inc_go;
    logic [NUM_CH-1:0] win_edge;
    logic [NUM_CH-1:0] w1c;
    logic [WIDTH-1:0]  scores [NUM_CH];
    logic              unused_wd;

    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_status = wr && (address == ADDR_STATUS);
    assign wr_thresh = wr && (address == ADDR_THRESH);
    assign clear_all = wr_ctrl && writedata[CTRL_CLEAR_ALL];
    assign frozen    = ctrl_q[CTRL_FREEZE] && (|status_q);
    assign inc_go    = inc & {NUM_CH{ctrl_q[CTRL_INC_EN] && !frozen}};
    assign w1c       = wr_status ? writedata[NUM_CH-1:0] : '0;
    assign irq       = |(status_q & {NUM_CH{ctrl_q[CTRL_IRQ_EN]}});
    assign unused_wd = ^writedata;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        score_channel #(.WIDTH(WIDTH)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear_all),
            .load     (wr && (address == 3'(i))),
            .load_val (writedata[WIDTH-1:0]),
            .inc_ok   (inc_go[i]),
            .thresh   (thresh_q),
            .score    (scores[i]),
            .win_edge (win_edge[i]),
            .win      (win[i])
        );
        assign out_port[i*WIDTH +: WIDTH] = scores[i];
    end

    // CTRL keeps only the persistent bits; clear_all is a pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ctrl_q <= '0;
        else if (wr_ctrl)
            ctrl_q <= writedata[2:0];
    end

    // STATUS: win edges set, W1C clears, a set on the same bit wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            status_q <= '0;
        else if (clear_all)
            status_q <= '0;
        else
            status_q <= (status_q & ~w1c) | win_edge;
    end

    // win threshold, zero disables win detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            thresh_q <= WIDTH'(MAX_SCORE);
        else if (wr_thresh)
            thresh_q <= writedata[WIDTH-1:0];
    end

    // read mux, zero-extended, unmapped addresses read 0
    always_comb begin
        readdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (address == 3'(i))
                readdata = 32'(scores[i]);
        case (address)
            ADDR_CTRL:   readdata = {29'b0, ctrl_q};
            ADDR_STATUS: readdata = 32'(status_q);
            ADDR_THRESH: readdata = 32'(thresh_q);
            default:     ;
        endcase
    end

endmodule

// File: tb/tb_avalon_score_counter_pio.sv
// Self-checking bench for avalon_score_counter_pio (NUM_CH=2, WIDTH=7).
// Register table plus scoreboarded multi-cycle sequences.
module tb_avalon_score_counter_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  inc;
    logic [13:0] out_port;
    logic [1:0]  win;
    logic        irq;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] re;
        string       nm;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    vec_t vt[11];
    exp_t sb[$];

    avalon_score_counter_pio #(
        .NUM_CH(2), .WIDTH(7), .MAX_SCORE(11)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .inc        (inc),
        .out_port   (out_port),
        .win        (win),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] op(int s1, int s0);
        return 32'((s1 << 7) | s0);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_wr(logic [2:0] a, logic [31:0] d, logic [1:0] m = 2'b00);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        inc        = m;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
        inc        = 2'b00;
    endtask

    task automatic rd(logic [2:0] a, logic [31:0] exp, string nm);
        exp_t e;
        address = a;
        sb.push_back('{nm, exp});
        #1;
        e = sb.pop_front();
        check(e.nm, readdata, e.v);
    endtask

    task automatic inc_step(logic [1:0] m, logic [31:0] exp, string nm);
        exp_t e;
        inc = m;
        sb.push_back('{nm, exp});
        cyc();
        inc = 2'b00;
        e = sb.pop_front();
        check(e.nm, 32'(out_port), e.v);
    endtask

    initial begin
        vt[0]  = '{3'd0, 32'h5,        3'd0, 32'h5,  "s0_rw"};
        vt[1]  = '{3'd1, 32'hFFFFFF85, 3'd1, 32'h5,  "s1_mask"};
        vt[2]  = '{3'd2, 32'h12,       3'd2, 32'h0,  "a2_rd0"};
        vt[3]  = '{3'd3, 32'h34,       3'd0, 32'h5,  "a3_nochg"};
        vt[4]  = '{3'd7, 32'hFF,       3'd7, 32'h0,  "a7_rd0"};
        vt[5]  = '{3'd7, 32'hFF,       3'd1, 32'h5,  "a7_nochg"};
        vt[6]  = '{3'd6, 32'h1FF,      3'd6, 32'h7F, "th_mask"};
        vt[7]  = '{3'd6, 32'd11,       3'd6, 32'd11, "th_rw"};
        vt[8]  = '{3'd4, 32'hF6,       3'd4, 32'h6,  "ctrl_rw"};
        vt[9]  = '{3'd5, 32'h3,        3'd5, 32'h0,  "st_idle"};
        vt[10] = '{3'd4, 32'h0,        3'd4, 32'h0,  "ctrl_zero"};

        reset = 1'b1; inc = '0; address = '0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_out", 32'(out_port), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_win", 32'(win), 0);
        rd(3'd4, 0, "rst_ctrl");
        rd(3'd5, 0, "rst_status");
        rd(3'd6, 11, "rst_thresh");

        for (int i = 0; i < 11; i++) begin
            bus_wr(vt[i].wa, vt[i].wd);
            rd(vt[i].ra, vt[i].re, vt[i].nm);
        end
        check("tbl_out", 32'(out_port), op(5, 5));
        bus_wr(3'd0, 0);
        bus_wr(3'd1, 0);

        // count up to the win threshold
        bus_wr(3'd4, 32'h3);
        for (int k = 1; k <= 10; k++)
            inc_step(2'b01, op(0, k), "inc_up");
        rd(3'd5, 0, "pre_win_st");
        inc_step(2'b01, op(0, 11), "inc_11");
        rd(3'd5, 1, "win_st");
        check("win_irq", 32'(irq), 1);
        check("win_lvl", 32'(win), 1);
        bus_wr(3'd5, 32'h1);
        check("w1c_irq", 32'(irq), 0);
        rd(3'd5, 0, "w1c_st");
        check("w1c_win", 32'(win), 1);

        // saturation with win detection disabled
        bus_wr(3'd1, 127);
        bus_wr(3'd6, 0);
        check("th0_win", 32'(win), 0);
        for (int k = 0; k < 3; k++)
            inc_step(2'b10, op(127, 11), "sat");
        rd(3'd5, 0, "sat_st");

        // freeze on win
        bus_wr(3'd0, 0);
        bus_wr(3'd1, 2);
        bus_wr(3'd6, 5);
        bus_wr(3'd4, 32'h7);
        for (int k = 1; k <= 5; k++)
            inc_step(2'b01, op(2, k), "frz_up");
        rd(3'd5, 1, "frz_st");
        inc_step(2'b11, op(2, 5), "frozen_a");
        inc_step(2'b11, op(2, 5), "frozen_b");
        bus_wr(3'd5, 32'h1);
        rd(3'd5, 0, "frz_clr");
        inc_step(2'b10, op(3, 5), "unfrozen");

        // collisions
        bus_wr(3'd4, 32'h3);
        bus_wr(3'd6, 11);
        bus_wr(3'd0, 3, 2'b01);
        check("wr_vs_inc", 32'(out_port), op(3, 3));
        bus_wr(3'd0, 10);
        bus_wr(3'd5, 32'h1, 2'b01);
        rd(3'd5, 1, "set_vs_w1c");
        check("set_vs_w1c_out", 32'(out_port), op(3, 11));

        // clear_all
        bus_wr(3'd5, 32'h1);
        bus_wr(3'd0, 4);
        bus_wr(3'd1, 8);
        bus_wr(3'd6, 9);
        inc_step(2'b10, op(9, 4), "ca_pre");
        rd(3'd5, 2, "ca_pre_st");
        check("ca_pre_irq", 32'(irq), 1);
        bus_wr(3'd4, 32'h9, 2'b10);
        check("ca_out", 32'(out_port), 0);
        rd(3'd5, 0, "ca_st");
        rd(3'd4, 1, "ca_ctrl");
        rd(3'd6, 9, "ca_thresh");
        check("ca_irq", 32'(irq), 0);

        // CPU write reaching threshold: win level, no status
        bus_wr(3'd0, 9);
        check("cpu_win", 32'(win), 1);
        rd(3'd5, 0, "cpu_win_st");

        // asynchronous reset mid-traffic
        bus_wr(3'd4, 32'h3);
        inc = 2'b11;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_out", 32'(out_port), 0);
        check("arst_irq", 32'(irq), 0);
        check("arst_win", 32'(win), 0);
        @(negedge clk);
        inc = 2'b00;
        reset = 1'b0;
        rd(3'd6, 11, "arst_thresh");
        rd(3'd4, 0, "arst_ctrl");
        rd(3'd5, 0, "arst_st");
        cyc();
        check("arst_hold", 32'(out_port), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_score_counter_pio.md
Name: avalon_score_counter_pio

Overview:
Parametrised Avalon-MM slave for scoreboard output. It holds NUM_CH score counters that software can write and that game logic can increment with one-cycle strobes. Each counter drives a WIDTH-bit slice of out_port. On top of the plain output register it adds saturating hardware increment, a programmable win threshold, edge-captured win status with write-1-to-clear, and a level interrupt. It sits on the Qsys fabric between the Nios master and the score display/decoder logic.

Parameters:
NUM_CH, 2, number of score channels (1..4).
WIDTH, 7, bits per score counter (1..16).
MAX_SCORE, 11, reset value of the win threshold register (must fit in WIDTH).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
address  in  3  Avalon word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe.
writedata  in  32  write data.
readdata  out  32  read data; combinational from address, zero-extended.
inc  in  NUM_CH  per-channel increment strobe, one clk per event.
out_port  out  NUM_CH*WIDTH  score[i] at bits [i*WIDTH +: WIDTH].
win  out  NUM_CH  level; score[i] >= threshold and threshold != 0.
irq  out  1  |(status & {NUM_CH{ctrl.irq_en}}).

Behaviour:
- Write = chipselect && !write_n. Register map by word address:
  - 0..3: SCORE[i], R/W, [WIDTH-1:0]. Addresses >= NUM_CH read 0 and ignore writes.
  - 4: CTRL, R/W. bit0 inc_en, bit1 irq_en, bit2 freeze_on_win, bit3 clear_all (write-only, self-clearing, reads 0).
  - 5: STATUS, [NUM_CH-1:0] win-edge flags, write-1-to-clear.
  - 6: THRESH, R/W, [WIDTH-1:0].
  - 7: reserved; reads 0, writes ignored.
- Reset (async, immediate): all SCORE=0, CTRL=0, STATUS=0, THRESH=MAX_SCORE. Outputs: out_port=0, win=0, irq=0. Reset asserted mid-game discards pending strobes.
- Increment: on clk edge with inc[i]=1, inc_en=1, and not frozen, SCORE[i] <= SCORE[i]+1. Saturates at 2^WIDTH-1 (no wrap). out_port reflects the new value after that edge (latency 1).
- Frozen = freeze_on_win && (STATUS != 0). While frozen, all inc strobes are dropped (not queued).
- Win edge: STATUS[i] sets on the same edge where an increment moves SCORE[i] from < THRESH to >= THRESH. THRESH=0 disables win detection, win and STATUS setting.
- CPU writes to SCORE or THRESH never set STATUS. The win output updates combinationally from the new values.
- Priority on same channel, same cycle: clear_all > CPU SCORE write > inc. The inc is lost in both override cases.
- STATUS W1C collides with set on the same bit: set wins.
- clear_all: zeroes all SCORE and STATUS in one cycle. CTRL other bits take the written value. THRESH is unchanged.
- Multiple inc bits in one cycle: each channel is handled independently. Both may set STATUS in the same cycle.
- irq: combinational from registered STATUS/CTRL; asserts the cycle after the setting edge and deasserts after W1C or clear_all.
- writedata bits above a register's width are ignored. Reads return zero in unused upper bits.

Decomposition:
- Package score_pio_pkg holds:
  - address constants ADDR_CTRL=4, ADDR_STATUS=5, ADDR_THRESH=6;
  - CTRL bit-index constants;
  - the max channel count 4.
- One sub-module, score_channel, is natural: a WIDTH-bit saturating counter with load, clear, inc_ok and thresh inputs, and win_edge and win outputs. It is instantiated NUM_CH times by generate. The top handles decode, CTRL/STATUS/THRESH and the read mux.

Test Plan:
- Reset defaults: assert reset mid-traffic -> out_port=0, irq=0, read THRESH=11, read CTRL=0, read STATUS=0.
- Increment to win: CTRL=0x3, pulse inc[0] 11 times -> SCORE0=11, STATUS=0x1 on 11th edge, irq=1 next cycle; write STATUS=0x1 -> irq=0.
- Saturation and freeze: WIDTH=7, SCORE1 written 127, THRESH=0, inc[1] pulses -> stays 127, no STATUS. Then THRESH=5, freeze_on_win=1, channel 0 reaches 5 -> further inc[0]/inc[1] ignored until STATUS cleared.
- Collisions: same cycle SCORE0 write 3 + inc[0] -> SCORE0=3. W1C STATUS bit0 + win edge on ch0 -> STATUS bit0 stays 1.
- clear_all: scores 4/9, STATUS=0x2, write CTRL=0x9 with inc[1] same cycle -> scores 0/0, STATUS=0, CTRL reads 0x1, THRESH unchanged.
- Decode: NUM_CH=2, write address 2, 3 and 7 -> no state change, reads 0. CPU write SCORE0=THRESH -> win[0]=1, STATUS unchanged.
